// File: rtl/tt_ctrl_seq.sv
// Sequencer that converts a "select design N" request into the mux controller's pin sequence.
// Optional `TT_CTRL_SEQ_RELATIVE_EN`: if the counter can count up to the target, skip its reset and issue only the extra pulses.
module tt_ctrl_seq #(
    parameter int ADDR_W        = 10,
    parameter int GUARD_CYCLES  = 1,
    parameter int RST_CYCLES    = 2,
    parameter int HALF_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sel_cur,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIS    = 3'd1;
    localparam logic [2:0] S_RST    = 3'd2;
    localparam logic [2:0] S_INC_HI = 3'd3;
    localparam logic [2:0] S_INC_LO = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;
    localparam logic [2:0] S_ACTIVE = 3'd6;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] target;

    // Outputs are registered alongside the state so they change exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            sel_cur        <= '0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            busy           <= 1'b0;
            req_ready      <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_ACTIVE: begin
                    if (req_valid) begin
                        target    <= req_addr;
                        state     <= S_DIS;
                        cnt       <= '0;
                        ctrl_ena  <= 1'b0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                S_DIS: begin
                    if (cnt == GUARD_LAST) begin
                        cnt <= '0;
`ifdef TT_CTRL_SEQ_RELATIVE_EN
                        // Counting up is only safe when the counter is out of reset and not past the target.
                        if (ctrl_sel_rst_n && (target >= sel_cur)) begin
                            if (target == sel_cur) begin
                                state <= S_SETTLE;
                            end else begin
                                state        <= S_INC_HI;
                                ctrl_sel_inc <= 1'b1;
                                sel_cur      <= sel_cur + 1'b1;
                            end
                        end else begin
                            state          <= S_RST;
                            ctrl_sel_rst_n <= 1'b0;
                            sel_cur        <= '0;
                        end
`else
                        state          <= S_RST;
                        ctrl_sel_rst_n <= 1'b0;
                        sel_cur        <= '0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt            <= '0;
                        ctrl_sel_rst_n <= 1'b1;
                        if (target != '0) begin
                            state        <= S_INC_HI;
                            ctrl_sel_inc <= 1'b1;
                            sel_cur      <= sel_cur + 1'b1;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INC_HI: begin
                    if (cnt == HALF_LAST) begin
                        cnt          <= '0;
                        ctrl_sel_inc <= 1'b0;
                        state        <= S_INC_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INC_LO: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (sel_cur != target) begin
                            state        <= S_INC_HI;
                            ctrl_sel_inc <= 1'b1;
                            sel_cur      <= sel_cur + 1'b1;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt       <= '0;
                        state     <= S_ACTIVE;
                        ctrl_ena  <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
